// File: rtl/image_frame_renderer.sv
// Image window renderer: turns a raster scan (x, y) into framebuffer reads and colours the
// returned pixel, with a white border around the window and black blanking.
module image_frame_renderer #(
    parameter int         X_OFF  = 80,
    parameter int         IMG_W  = 480,
    parameter int         IMG_H  = 480,
    parameter int         PIX_W  = 8,
    parameter int         ADDR_W = 18,
    parameter int         RD_LAT = 1,
    parameter logic [7:0] THRESH = 8'd128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              video_on,
    input  logic [1:0]        mode,
    input  logic              scale2x,
    input  logic [PIX_W-1:0]  ReadData,
    output logic [ADDR_W-1:0] Address,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              pix_valid
);

    typedef enum logic [1:0] {CLS_BLANK, CLS_BORDER, CLS_IMG, CLS_DARK} cls_t;
    typedef enum logic {IDLE, ARMED} state_t;
    typedef struct packed {
        cls_t       cls;
        logic [1:0] mode;
    } tag_t;

    localparam logic [31:0] X_LO = X_OFF;
    localparam logic [31:0] X_HI = X_OFF + IMG_W;
    localparam logic [31:0] Y_HI = IMG_H;

    localparam logic [ADDR_W-1:0] STEP1     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] STEP2     = ADDR_W'(IMG_W / 2);
    localparam logic [ADDR_W-1:0] COL_LAST1 = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] COL_LAST2 = ADDR_W'(IMG_W / 2 - 1);
    localparam logic [ADDR_W-1:0] LB_LAST1  = ADDR_W'(IMG_W * (IMG_H - 1));
    localparam logic [ADDR_W-1:0] LB_LAST2  = ADDR_W'((IMG_W / 2) * (IMG_H / 2 - 1));

    state_t              state;
    logic [1:0]          frame_mode;
    logic                frame_scale;
    logic [ADDR_W-1:0]   line_base;
    logic [ADDR_W-1:0]   col_cnt;
    logic                col_phase;
    tag_t [RD_LAT:0]     pipe;

    logic [31:0]         xw;
    logic [31:0]         yw;
    logic                in_win;
    logic                in_img;
    logic                frame_start;
    logic                armed_now;
    logic                scale_eff;
    logic [1:0]          mode_eff;
    tag_t                tag_in;
    tag_t                out_tag;

    logic [ADDR_W-1:0]   lb_cur, col_cur, lb_nxt, col_nxt, addr_nxt;
    logic                ph_cur, ph_nxt;
    logic [7:0]          p;
    logic [7:0]          r_nxt, g_nxt, b_nxt, q;

    assign xw          = {22'd0, x};
    assign yw          = {22'd0, y};
    assign in_win      = (xw >= X_LO) && (xw < X_HI) && (yw < Y_HI);
    assign in_img      = video_on && in_win;
    assign frame_start = video_on && (x == 10'd0) && (y == 10'd0);
    // The frame-start sample itself already runs under the newly latched settings.
    assign armed_now   = (state == ARMED) || frame_start;
    assign scale_eff   = frame_start ? scale2x : frame_scale;
    assign mode_eff    = frame_start ? mode : frame_mode;

    always_comb begin
        tag_in.mode = mode_eff;
        if (!video_on)     tag_in.cls = CLS_BLANK;
        else if (!in_win)  tag_in.cls = CLS_BORDER;
        else if (armed_now) tag_in.cls = CLS_IMG;
        else               tag_in.cls = CLS_DARK;
    end

    always_comb begin
        lb_cur   = frame_start ? '0 : line_base;
        col_cur  = frame_start ? '0 : col_cnt;
        ph_cur   = frame_start ? 1'b0 : col_phase;
        lb_nxt   = lb_cur;
        col_nxt  = col_cur;
        ph_nxt   = ph_cur;
        addr_nxt = frame_start ? '0 : Address;
        if (armed_now && in_img) begin
            addr_nxt = lb_cur + col_cur;
            if (!scale_eff) begin
                if (col_cur == COL_LAST1) begin
                    col_nxt = '0;
                    lb_nxt  = (lb_cur == LB_LAST1) ? '0 : lb_cur + STEP1;
                end else begin
                    col_nxt = col_cur + ADDR_W'(1);
                end
            end else begin
                ph_nxt = ~ph_cur;
                if (ph_cur) begin
                    if (col_cur == COL_LAST2) begin
                        col_nxt = '0;
                        // Each source line is shown on an even/odd screen-line pair.
                        if (y[0]) lb_nxt = (lb_cur == LB_LAST2) ? '0 : lb_cur + STEP2;
                    end else begin
                        col_nxt = col_cur + ADDR_W'(1);
                    end
                end
            end
        end
    end

    generate
        if (PIX_W == 8) begin : g_full
            assign p = ReadData;
        end else begin : g_expand
            assign p = {ReadData, ReadData[PIX_W-1 -: 8-PIX_W]};
        end
    endgenerate

    always_comb begin
        out_tag = pipe[RD_LAT];
        r_nxt   = 8'h00;
        g_nxt   = 8'h00;
        b_nxt   = 8'h00;
        q       = 8'h00;
        case (out_tag.cls)
            CLS_BORDER: begin
                r_nxt = 8'hFF;
                g_nxt = 8'hFF;
                b_nxt = 8'hFF;
            end
            CLS_IMG: begin
                case (out_tag.mode)
                    2'b00: q = p;
                    2'b01: q = 8'hFF - p;
                    2'b10: q = (p >= THRESH) ? 8'hFF : 8'h00;
                    default: q = p;
                endcase
                r_nxt = q;
                g_nxt = (out_tag.mode == 2'b11) ? 8'h00 : q;
                b_nxt = (out_tag.mode == 2'b11) ? 8'h00 : q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            frame_mode  <= 2'b00;
            frame_scale <= 1'b0;
            line_base   <= '0;
            col_cnt     <= '0;
            col_phase   <= 1'b0;
            Address     <= '0;
            // NOTE: the tag pipeline is cleared too, so pre-reset pixels never reach the outputs.
            pipe        <= '0;
            red         <= 8'h00;
            green       <= 8'h00;
            blue        <= 8'h00;
            pix_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (frame_start) state <= ARMED;
                ARMED: state <= ARMED;
            endcase
            if (frame_start) begin
                frame_mode  <= mode;
                frame_scale <= scale2x;
            end
            line_base <= lb_nxt;
            col_cnt   <= col_nxt;
            col_phase <= ph_nxt;
            Address   <= addr_nxt;
            pipe      <= {pipe[RD_LAT-1:0], tag_in};
            red       <= r_nxt;
            green     <= g_nxt;
            blue      <= b_nxt;
            pix_valid <= (out_tag.cls != CLS_BLANK);
        end
    end

endmodule

// File: tb/tb_image_frame_renderer.sv
// Bench for image_frame_renderer: a default instance and a small PIX_W=4 / RD_LAT=2 instance,
// both checked every cycle against an arithmetic model plus pinned literal values.
module tb_image_frame_renderer;

    localparam int LA = 3;
    localparam int LB = 4;

    typedef struct {
        bit       armed;
        bit [1:0] fmode;
        bit       fscale;
        int       addr;
    } mst_t;

    typedef struct {
        int        addr;
        bit [23:0] rgb;
        bit        v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: default parameters
    logic        a_reset = 1'b1, a_von = 1'b0, a_scale = 1'b0;
    logic [9:0]  a_x = '0, a_y = '0;
    logic [1:0]  a_mode = 2'b00;
    logic [7:0]  a_rdata = '0;
    logic [17:0] a_address;
    logic [7:0]  a_red, a_green, a_blue;
    logic        a_pix_valid;

    // Instance B: small window, 4-bit pixels, two-clock memory
    logic        b_reset = 1'b1, b_von = 1'b0, b_scale = 1'b0;
    logic [9:0]  b_x = '0, b_y = '0;
    logic [1:0]  b_mode = 2'b00;
    logic [3:0]  b_stage = '0, b_rdata = '0;
    logic [5:0]  b_address;
    logic [7:0]  b_red, b_green, b_blue;
    logic        b_pix_valid;

    image_frame_renderer dut_a (
        .clk(clk), .reset(a_reset), .x(a_x), .y(a_y), .video_on(a_von),
        .mode(a_mode), .scale2x(a_scale), .ReadData(a_rdata), .Address(a_address),
        .red(a_red), .green(a_green), .blue(a_blue), .pix_valid(a_pix_valid)
    );

    image_frame_renderer #(
        .X_OFF(4), .IMG_W(8), .IMG_H(6), .PIX_W(4), .ADDR_W(6), .RD_LAT(2)
    ) dut_b (
        .clk(clk), .reset(b_reset), .x(b_x), .y(b_y), .video_on(b_von),
        .mode(b_mode), .scale2x(b_scale), .ReadData(b_rdata), .Address(b_address),
        .red(b_red), .green(b_green), .blue(b_blue), .pix_valid(b_pix_valid)
    );

    // Framebuffer contents: A holds addr[7:0], B holds addr[3:0]^4'hA
    always @(posedge clk) a_rdata <= a_address[7:0];
    always @(posedge clk) begin
        b_stage <= b_address[3:0] ^ 4'hA;
        b_rdata <= b_stage;
    end

    mst_t sa, sb;
    int          a_adr_exp[int];
    logic [24:0] a_col_exp[int];
    int          b_adr_exp[int];
    logic [24:0] b_col_exp[int];
    logic [23:0] want_a_rgb[int], want_b_rgb[int];
    int          want_a_adr[int], want_b_adr[int];
    logic [23:0] pin_a_rgb[int], pin_b_rgb[int];
    int          pin_a_adr[int], pin_b_adr[int];

    function automatic int mem_val(input int which, input int addr);
        if (which == 0) return addr % 256;
        return (addr % 16) ^ 10;
    endfunction

    function automatic bit [7:0] expand(input int v, input int pw);
        return 8'((v << (8 - pw)) | (v >> (2 * pw - 8)));
    endfunction

    function automatic exp_t model(input int which, input int xo, input int w, input int h,
                                   input int pw, input bit rst, input bit von, input int x,
                                   input int y, input bit [1:0] md, input bit sc, inout mst_t s);
        exp_t o;
        bit [7:0] pv, q;
        o.addr = 0;
        o.rgb  = 24'h0;
        o.v    = 1'b0;
        if (rst) begin
            s.armed = 1'b0; s.fmode = 2'b00; s.fscale = 1'b0; s.addr = 0;
            return o;
        end
        if (von && x == 0 && y == 0) begin
            s.armed = 1'b1; s.fmode = md; s.fscale = sc; s.addr = 0;
        end
        o.v = von;
        if (von) begin
            if (!(x >= xo && x < xo + w && y < h)) begin
                o.rgb = 24'hFFFFFF;
            end else if (s.armed) begin
                s.addr = s.fscale ? (y / 2) * (w / 2) + (x - xo) / 2 : y * w + (x - xo);
                pv = expand(mem_val(which, s.addr), pw);
                case (s.fmode)
                    2'd0: o.rgb = {pv, pv, pv};
                    2'd1: begin q = 8'hFF - pv; o.rgb = {q, q, q}; end
                    2'd2: begin q = (pv >= 8'd128) ? 8'hFF : 8'h00; o.rgb = {q, q, q}; end
                    default: o.rgb = {pv, 16'h0000};
                endcase
            end
        end
        o.addr = s.addr;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, req);
        end
    endtask

    task automatic step();
        exp_t ea, eb;
        int e, k;
        e  = edge_n;
        ea = model(0, 80, 480, 480, 8, a_reset, a_von, int'(a_x), int'(a_y), a_mode, a_scale, sa);
        eb = model(1, 4, 8, 6, 4, b_reset, b_von, int'(b_x), int'(b_y), b_mode, b_scale, sb);
        a_adr_exp[e + 1] = ea.addr;
        b_adr_exp[e + 1] = eb.addr;
        if (a_reset) for (int d = 1; d <= LA; d++) a_col_exp[e + d] = 25'd0;
        else a_col_exp[e + LA] = {ea.rgb, ea.v};
        if (b_reset) for (int d = 1; d <= LB; d++) b_col_exp[e + d] = 25'd0;
        else b_col_exp[e + LB] = {eb.rgb, eb.v};

        k = int'(a_x) * 1024 + int'(a_y);
        if (a_von && want_a_rgb.exists(k)) begin
            pin_a_rgb[a_reset ? e + 1 : e + LA] = want_a_rgb[k];
            want_a_rgb.delete(k);
        end
        if (a_von && want_a_adr.exists(k)) begin
            pin_a_adr[e + 1] = want_a_adr[k];
            want_a_adr.delete(k);
        end
        k = int'(b_x) * 1024 + int'(b_y);
        if (b_von && want_b_rgb.exists(k)) begin
            pin_b_rgb[b_reset ? e + 1 : e + LB] = want_b_rgb[k];
            want_b_rgb.delete(k);
        end
        if (b_von && want_b_adr.exists(k)) begin
            pin_b_adr[e + 1] = want_b_adr[k];
            want_b_adr.delete(k);
        end
        @(posedge clk);
        #1;
    endtask

    // Single compare process: model expectations and pinned literals
    always @(negedge clk) begin
        int n;
        n = edge_n;
        if (a_adr_exp.exists(n)) begin
            check("a_address", 32'(a_address), a_adr_exp[n]);
            a_adr_exp.delete(n);
        end
        if (a_col_exp.exists(n)) begin
            check("a_rgb", {8'h0, a_red, a_green, a_blue}, {8'h0, a_col_exp[n][24:1]});
            check("a_pix_valid", 32'(a_pix_valid), 32'(a_col_exp[n][0]));
            a_col_exp.delete(n);
        end
        if (b_adr_exp.exists(n)) begin
            check("b_address", 32'(b_address), b_adr_exp[n]);
            b_adr_exp.delete(n);
        end
        if (b_col_exp.exists(n)) begin
            check("b_rgb", {8'h0, b_red, b_green, b_blue}, {8'h0, b_col_exp[n][24:1]});
            check("b_pix_valid", 32'(b_pix_valid), 32'(b_col_exp[n][0]));
            b_col_exp.delete(n);
        end
        if (pin_a_rgb.exists(n)) begin
            check("a_rgb_literal", {8'h0, a_red, a_green, a_blue}, {8'h0, pin_a_rgb[n]});
            pin_a_rgb.delete(n);
        end
        if (pin_a_adr.exists(n)) begin
            check("a_address_literal", 32'(a_address), pin_a_adr[n]);
            pin_a_adr.delete(n);
        end
        if (pin_b_rgb.exists(n)) begin
            check("b_rgb_literal", {8'h0, b_red, b_green, b_blue}, {8'h0, pin_b_rgb[n]});
            pin_b_rgb.delete(n);
        end
        if (pin_b_adr.exists(n)) begin
            check("b_address_literal", 32'(b_address), pin_b_adr[n]);
            pin_b_adr.delete(n);
        end
    end

    function automatic int key(input int x, input int y);
        return x * 1024 + y;
    endfunction

    task automatic a_px(input int x, input int y);
        a_x = 10'(x); a_y = 10'(y); a_von = 1'b1;
        step();
    endtask

    task automatic a_blank(input int n);
        a_von = 1'b0;
        repeat (n) step();
    endtask

    task automatic a_line(input int y, input int x0, input int x1);
        for (int xx = x0; xx <= x1; xx++) a_px(xx, y);
        a_blank(2);
    endtask

    task automatic b_px(input int x, input int y);
        b_x = 10'(x); b_y = 10'(y); b_von = 1'b1;
        step();
    endtask

    task automatic b_frame();
        for (int yy = 0; yy < 8; yy++) begin
            for (int xx = 0; xx < 16; xx++) b_px(xx, yy);
            b_von = 1'b0;
            repeat (2) step();
        end
    endtask

    initial begin
        sa = '{1'b0, 2'b00, 1'b0, 0};
        sb = '{1'b0, 2'b00, 1'b0, 0};
        repeat (2) step();
        a_reset = 1'b0;
        b_reset = 1'b0;
        a_blank(2);

        // Window pixels before the first frame start stay black
        want_a_rgb[key(100, 5)] = 24'h000000;
        want_a_adr[key(100, 5)] = 0;
        a_px(100, 5); a_px(101, 5); a_px(20, 5);
        a_blank(2);

        // Frame 1: mode 00, 1x; mode request mid-frame is ignored
        want_a_rgb[key(80, 0)]  = 24'h000000;
        want_a_rgb[key(81, 0)]  = 24'h010101;
        want_a_rgb[key(79, 0)]  = 24'hFFFFFF;
        want_a_rgb[key(560, 0)] = 24'hFFFFFF;
        want_a_rgb[key(81, 1)]  = 24'hE1E1E1;
        want_a_adr[key(0, 0)]   = 0;
        want_a_adr[key(558, 0)] = 478;
        want_a_adr[key(559, 0)] = 479;
        want_a_adr[key(560, 0)] = 479;
        want_a_adr[key(80, 1)]  = 480;
        a_mode = 2'b00; a_scale = 1'b0;
        a_px(0, 0); a_blank(3);
        a_line(0, 78, 561);
        a_mode = 2'b01;
        a_line(1, 78, 561);
        a_line(2, 78, 561);

        // Frame 2: mode 01, request for 10 mid-frame has no effect
        want_a_rgb[key(224, 0)] = 24'h6F6F6F;
        want_a_rgb[key(225, 0)] = 24'h6E6E6E;
        a_px(0, 0); a_blank(2);
        a_mode = 2'b10;
        a_line(0, 78, 561);

        // Frame 3: mode 10, threshold boundary
        want_a_rgb[key(224, 0)] = 24'hFFFFFF;
        want_a_rgb[key(207, 0)] = 24'h000000;
        want_a_rgb[key(208, 0)] = 24'hFFFFFF;
        a_px(0, 0); a_blank(2);
        a_line(0, 78, 561);

        // Frame 4: mode 11
        want_a_rgb[key(224, 0)] = 24'h900000;
        a_mode = 2'b11;
        a_px(0, 0); a_blank(2);
        a_line(0, 78, 561);

        // Frame 5: scale 2x
        want_a_adr[key(80, 0)]  = 0;
        want_a_adr[key(81, 0)]  = 0;
        want_a_adr[key(82, 0)]  = 1;
        want_a_adr[key(559, 0)] = 239;
        want_a_adr[key(80, 1)]  = 0;
        want_a_adr[key(559, 1)] = 239;
        want_a_adr[key(80, 2)]  = 240;
        want_a_adr[key(81, 2)]  = 240;
        a_mode = 2'b00; a_scale = 1'b1;
        a_px(0, 0); a_blank(2);
        a_line(0, 78, 561);
        a_line(1, 78, 561);
        a_scale = 1'b0;
        a_line(2, 78, 561);

        // Frame 6: reset in mid-frame at (300,200)
        a_px(0, 0); a_blank(2);
        a_line(0, 78, 561);
        a_line(1, 78, 561);
        want_a_rgb[key(300, 200)] = 24'h000000;
        want_a_adr[key(300, 200)] = 0;
        a_reset = 1'b1;
        a_px(300, 200);
        a_reset = 1'b0;
        want_a_rgb[key(301, 200)] = 24'h000000;
        want_a_adr[key(301, 200)] = 0;
        want_a_rgb[key(30, 200)]  = 24'hFFFFFF;
        a_line(200, 298, 310);
        a_px(30, 200);
        a_blank(3);
        want_a_adr[key(80, 0)] = 0;
        want_a_adr[key(81, 0)] = 1;
        want_a_rgb[key(81, 0)] = 24'h010101;
        a_px(0, 0); a_blank(2);
        a_line(0, 78, 90);

        // Instance B: full frames, 4-bit expansion, frame wrap, 2x
        want_b_rgb[key(4, 0)]  = 24'hAAAAAA;
        want_b_rgb[key(5, 0)]  = 24'hBBBBBB;
        want_b_adr[key(11, 5)] = 47;
        b_mode = 2'b00; b_scale = 1'b0;
        b_frame();
        want_b_adr[key(4, 0)]  = 0;
        want_b_adr[key(11, 5)] = 47;
        want_b_rgb[key(4, 0)]  = 24'hAA0000;
        want_b_rgb[key(5, 0)]  = 24'hBB0000;
        b_mode = 2'b11;
        b_frame();
        want_b_adr[key(4, 1)]  = 0;
        want_b_adr[key(4, 2)]  = 4;
        want_b_adr[key(11, 5)] = 11;
        want_b_rgb[key(4, 0)]  = 24'h555555;
        b_mode = 2'b01; b_scale = 1'b1;
        b_frame();
        b_scale = 1'b0;
        b_frame();

        a_von = 1'b0; b_von = 1'b0;
        repeat (8) step();

        foreach (want_a_rgb[k]) begin n_errors++; $display("FAIL a_literal_unreached key=%0d", k); end
        foreach (want_a_adr[k]) begin n_errors++; $display("FAIL a_literal_unreached key=%0d", k); end
        foreach (want_b_rgb[k]) begin n_errors++; $display("FAIL b_literal_unreached key=%0d", k); end
        foreach (want_b_adr[k]) begin n_errors++; $display("FAIL b_literal_unreached key=%0d", k); end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
